// File: rtl/question_gen.sv
// Question generator: a free-running Galois LFSR supplies operands and opcode, which are
// constrained so the 8-bit answer never overflows. Optional macro: QUESTION_GEN_NONZERO_EN.
module question_gen #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        flush,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic        q_valid,
    input  logic        q_ready,
    output logic [7:0]  q1,
    output logic [7:0]  q2,
    output logic [1:0]  op,
    output logic [7:0]  expected
);

    localparam logic [15:0] TAPS      = 16'hB400;
    localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_DRAW    = 2'b01,
        ST_CHECK   = 2'b10,
        ST_PRESENT = 2'b11
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? TAPS : 16'h0000);
    endfunction

    // An all-zero LFSR would lock up, so zero is never loaded.
    function automatic logic [15:0] nonzero_seed(input logic [15:0] v);
        nonzero_seed = (v == 16'h0000) ? 16'h0001 : v;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [15:0] lfsr_r;
    logic        q_valid_r;
    logic [7:0]  q1_r;
    logic [7:0]  q2_r;
    logic [1:0]  op_r;
    logic [7:0]  exp_r;

    logic [7:0]  a_s;
    logic [7:0]  b_s;
    logic [1:0]  cand_op_s;
    logic [7:0]  draw_q1_s;
    logic [7:0]  draw_q2_s;
    logic        draw_ok_s;
    logic        swap_s;
    logic [7:0]  hi_s;
    logic [7:0]  lo_s;
    logic [15:0] prod_s;
    logic [7:0]  exp_s;

    // Candidate operands and opcode drawn from the current LFSR value.
    always_comb begin
        a_s       = lfsr_r[15:8];
        b_s       = lfsr_r[7:0];
        cand_op_s = lfsr_r[11:10] ^ lfsr_r[3:2];
        draw_q1_s = a_s;
        draw_q2_s = b_s;
        case (cand_op_s)
            2'b00: begin
                draw_q1_s = {1'b0, a_s[6:0]};
                draw_q2_s = {1'b0, b_s[6:0]};
            end
            2'b01: begin
                draw_q1_s = {4'b0000, a_s[3:0]};
                draw_q2_s = {4'b0000, b_s[3:0]};
            end
            2'b11: begin
                draw_q1_s = a_s;
                draw_q2_s = b_s;
            end
            default: begin
                draw_q1_s = a_s;
                draw_q2_s = b_s;
            end
        endcase
`ifdef QUESTION_GEN_NONZERO_EN
        draw_ok_s = (cand_op_s != 2'b10) && (draw_q1_s != 8'h00) && (draw_q2_s != 8'h00);
`else
        draw_ok_s = (cand_op_s != 2'b10);
`endif
    end

    // Subtract operands are ordered larger-first; masked ranges keep every result in 8 bits.
    always_comb begin
        swap_s = (op_r == 2'b11) && (q1_r < q2_r);
        hi_s   = swap_s ? q2_r : q1_r;
        lo_s   = swap_s ? q1_r : q2_r;
        prod_s = {8'h00, hi_s} * {8'h00, lo_s};
        case (op_r)
            2'b00:   exp_s = hi_s + lo_s;
            2'b01:   exp_s = prod_s[7:0];
            2'b11:   exp_s = hi_s - lo_s;
            default: exp_s = 8'h00;
        endcase
    end

    // Next-state logic; flush overrides every other input.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_s = req ? ST_DRAW : ST_IDLE;
                ST_DRAW:    state_s = draw_ok_s ? ST_CHECK : ST_DRAW;
                ST_CHECK:   state_s = ST_PRESENT;
                ST_PRESENT: state_s = (q_valid_r && q_ready) ? ST_IDLE : ST_PRESENT;
                default:    state_s = ST_IDLE;
            endcase
        end
    end

    // LFSR steps every cycle unless a seed is loaded.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr_r <= SEED_SAFE;
        end else if (seed_load) begin
            lfsr_r <= nonzero_seed(seed);
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // State register and registered valid flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            q_valid_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            q_valid_r <= (state_s == ST_PRESENT);
        end
    end

    // Question registers load in DRAW and CHECK only and otherwise hold.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q1_r  <= 8'h00;
            q2_r  <= 8'h00;
            op_r  <= 2'b00;
            exp_r <= 8'h00;
        end else if (!flush && (state_r == ST_DRAW) && draw_ok_s) begin
            q1_r <= draw_q1_s;
            q2_r <= draw_q2_s;
            op_r <= cand_op_s;
        end else if (!flush && (state_r == ST_CHECK)) begin
            q1_r  <= hi_s;
            q2_r  <= lo_s;
            exp_r <= exp_s;
        end else begin
            q1_r  <= q1_r;
            q2_r  <= q2_r;
            op_r  <= op_r;
            exp_r <= exp_r;
        end
    end

    assign q_valid  = q_valid_r;
    assign q1       = q1_r;
    assign q2       = q2_r;
    assign op       = op_r;
    assign expected = exp_r;

endmodule
